// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Shows a 16-bit value as four hex digits on a common-anode 7-segment
// display. The digits are time-multiplexed. Each digit window is
// REFRESH_DIV cycles long. The first cycle of every window is blanked so
// the previous digit does not ghost onto the next anode. Leading zeros can
// be suppressed, and a hold input freezes the displayed value.
//
// Control semantics: load is a level-sensitive capture enable, and hold
// overrides it. There is no handshake. The display always scans, and din
// never reaches the outputs combinationally.
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 50000,  // clk cycles per digit window, 2..65535
    parameter bit BLANK_LZ    = 1'b1    // 1: blank leading zero digits 3..1
) (
    input  logic        clk,
    input  logic        rst,   // asynchronous, active-low
    input  logic [15:0] din,
    input  logic        load,
    input  logic        hold,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [15:0]   r_shadow;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [3:0]    w_nib;
    logic          w_lz;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    // Active-low gfedcba patterns for one hex nibble
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Shadow register: capture din on load unless the display is frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= 16'h0000;
        end else if (load && !hold) begin
            r_shadow <= din;
        end
    end

    // Window counter and digit index; idx advances as cnt wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Select the active nibble and decide whether it is a leading zero
    always_comb begin
        w_nib = 4'h0;
        w_lz  = 1'b0;
        case (r_idx)
            2'd0: w_nib = r_shadow[3:0];
            2'd1: begin
                w_nib = r_shadow[7:4];
                w_lz  = (r_shadow[15:4] == 12'h000);
            end
            2'd2: begin
                w_nib = r_shadow[11:8];
                w_lz  = (r_shadow[15:8] == 8'h00);
            end
            default: begin
                w_nib = r_shadow[15:12];
                w_lz  = (r_shadow[15:12] == 4'h0);
            end
        endcase
    end

    // Next output value: blank on the first cycle of each window, else drive the digit
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 7'b1111111;
        w_dp_nxt  = 1'b1;
        if (r_cnt != '0) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = (BLANK_LZ && w_lz) ? 7'b1111111 : hex_decode(w_nib);
            w_dp_nxt  = ~((r_idx == 2'd0) && hold);
        end
    end

    // Output register: drives the pins glitch-free, one cycle after the counter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver
// Directed bench for ssd_scan_driver. Three instances share one set of
// inputs: REFRESH_DIV=4 with blanking, REFRESH_DIV=4 without blanking,
// and REFRESH_DIV=2 with blanking.
module tb_ssd_scan_driver;

    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_4  = 7'b0011001;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_A  = 7'b0001000;
    localparam logic [6:0] S_B  = 7'b0000011;
    localparam logic [6:0] S_E  = 7'b0000110;
    localparam logic [6:0] S_F  = 7'b0001110;
    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [11:0] RST_VEC = {4'b1111, 7'b1111111, 1'b1};

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        load;
    logic        hold;
    logic [3:0]  an,   an_nolz,  an_d2;
    logic [6:0]  seg,  seg_nolz, seg_d2;
    logic        dp,   dp_nolz,  dp_d2;

    int n_checks = 0;
    int n_errors = 0;

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .din(din), .load(load), .hold(hold),
        .an(an), .seg(seg), .dp(dp)
    );

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_nolz (
        .clk(clk), .rst(rst), .din(din), .load(load), .hold(hold),
        .an(an_nolz), .seg(seg_nolz), .dp(dp_nolz)
    );

    ssd_scan_driver #(.REFRESH_DIV(2), .BLANK_LZ(1'b1)) u_dut_d2 (
        .clk(clk), .rst(rst), .din(din), .load(load), .hold(hold),
        .an(an_d2), .seg(seg_d2), .dp(dp_d2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed an/seg/dp=%b expected %b", tag, obs, exp);
        end
    endtask

    // Assert reset for two edges, check reset outputs, release after an edge
    task automatic do_reset(input string ph);
        rst = 1'b0;
        #1;
        chk({ph, " rst_now"}, {an, seg, dp}, RST_VEC);
        tick();
        tick();
        chk({ph, " rst"},      {an, seg, dp}, RST_VEC);
        chk({ph, " rst_d2"},   {an_d2, seg_d2, dp_d2}, RST_VEC);
        rst = 1'b1;
    endtask

    // One REFRESH_DIV=4 digit window: blank edge, then three active edges
    task automatic chk_window(input string ph, input int d, input logic [6:0] s_lz,
                              input logic [6:0] s_nolz, input logic dp_e);
        logic [3:0] an_e;
        an_e    = 4'b1111;
        an_e[d] = 1'b0;
        tick();
        chk($sformatf("%s d%0d blank", ph, d), {an, seg, dp}, RST_VEC);
        chk($sformatf("%s d%0d blank_nolz", ph, d), {an_nolz, seg_nolz, dp_nolz}, RST_VEC);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("%s d%0d act%0d", ph, d, i), {an, seg, dp}, {an_e, s_lz, dp_e});
            chk($sformatf("%s d%0d act%0d_nolz", ph, d, i), {an_nolz, seg_nolz, dp_nolz},
                {an_e, s_nolz, dp_e});
        end
    endtask

    // One REFRESH_DIV=2 digit window: blank edge, one active edge
    task automatic chk_d2(input int s, input int d, input logic [6:0] s_e);
        logic [3:0] an_e;
        an_e    = 4'b1111;
        an_e[d] = 1'b0;
        tick();
        chk($sformatf("d2 scan%0d d%0d blank", s, d), {an_d2, seg_d2, dp_d2}, RST_VEC);
        tick();
        chk($sformatf("d2 scan%0d d%0d act", s, d), {an_d2, seg_d2, dp_d2}, {an_e, s_e, 1'b1});
    endtask

    logic [6:0] d2_segs [4];

    initial begin
        rst  = 1'b0;
        din  = 16'h0000;
        load = 1'b0;
        hold = 1'b0;
        tick();

        // Reset, first digit and full rotation for 0x12AB
        din  = 16'h12AB;
        load = 1'b1;
        do_reset("rot");
        chk_window("rot", 0, S_B, S_B, 1'b1);
        chk_window("rot", 1, S_A, S_A, 1'b1);
        chk_window("rot", 2, S_2, S_2, 1'b1);
        chk_window("rot", 3, S_1, S_1, 1'b1);
        chk_window("rot", 0, S_B, S_B, 1'b1);

        // Leading zeros, value 0x0005
        din = 16'h0005;
        do_reset("lz5");
        chk_window("lz5", 0, S_5,  S_5, 1'b1);
        chk_window("lz5", 1, S_BL, S_0, 1'b1);
        chk_window("lz5", 2, S_BL, S_0, 1'b1);
        chk_window("lz5", 3, S_BL, S_0, 1'b1);

        // Leading zeros, value 0x0000
        din = 16'h0000;
        do_reset("lz0");
        chk_window("lz0", 0, S_0,  S_0, 1'b1);
        chk_window("lz0", 1, S_BL, S_0, 1'b1);

        // Hold precedence: freeze 0xBEEF while load stays high with 0x1234
        din = 16'hBEEF;
        do_reset("hold");
        chk_window("hold", 0, S_F, S_F, 1'b1);
        chk_window("hold", 1, S_E, S_E, 1'b1);
        chk_window("hold", 2, S_E, S_E, 1'b1);
        chk_window("hold", 3, S_B, S_B, 1'b1);
        hold = 1'b1;
        din  = 16'h1234;
        chk_window("hold", 0, S_F, S_F, 1'b0);
        chk_window("hold", 1, S_E, S_E, 1'b1);
        chk_window("hold", 2, S_E, S_E, 1'b1);
        chk_window("hold", 3, S_B, S_B, 1'b1);
        hold = 1'b0;
        chk_window("unhold", 0, S_4, S_4, 1'b1);
        chk_window("unhold", 1, S_3, S_3, 1'b1);

        // Asynchronous reset during a digit-2 active cycle
        din = 16'h12AB;
        do_reset("arst");
        chk_window("arst", 0, S_B, S_B, 1'b1);
        chk_window("arst", 1, S_A, S_A, 1'b1);
        tick();
        chk("arst d2 blank", {an, seg, dp}, RST_VEC);
        tick();
        chk("arst d2 act", {an, seg, dp}, {4'b1011, S_2, 1'b1});
        #2;
        rst = 1'b0;
        #1;
        chk("arst immediate", {an, seg, dp}, RST_VEC);
        chk("arst immediate_nolz", {an_nolz, seg_nolz, dp_nolz}, RST_VEC);
        tick();
        chk("arst held", {an, seg, dp}, RST_VEC);
        rst = 1'b1;
        chk_window("arst restart", 0, S_B, S_B, 1'b1);
        chk_window("arst restart", 1, S_A, S_A, 1'b1);

        // Minimum divider: blank/active per digit, three full scans plus a wrap
        din = 16'h12AB;
        do_reset("d2");
        d2_segs[0] = S_B;
        d2_segs[1] = S_A;
        d2_segs[2] = S_2;
        d2_segs[3] = S_1;
        for (int s = 0; s < 3; s++) begin
            for (int d = 0; d < 4; d++) begin
                chk_d2(s, d, d2_segs[d]);
            end
        end
        chk_d2(3, 0, S_B);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
